// File: rtl/lz77_stream_encoder.sv
// Streaming LZ77 encoder: sliding window fed over valid/ready, one (offset, match_len, char_nxt) token per handshake.
// Define LZ77_PARALLEL_SEARCH_EN to evaluate every search candidate in a single cycle.
module lz77_stream_encoder #(
  parameter int unsigned       DATA_W     = 8,
  parameter int unsigned       SEARCH_LEN = 9,
  parameter int unsigned       LOOK_LEN   = 8,
  parameter int unsigned       OFF_W      = 4,
  parameter int unsigned       LEN_W      = 3,
  parameter logic [DATA_W-1:0] TERM_CHAR  = 8'h24,
  parameter logic [DATA_W-1:0] FILL_CHAR  = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] chardata,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              valid,
  input  logic              out_ready,
  output logic              encode,
  output logic              finish,
  output logic [OFF_W-1:0]  offset,
  output logic [LEN_W-1:0]  match_len,
  output logic [DATA_W-1:0] char_nxt
);

  localparam int unsigned WIN_LEN = SEARCH_LEN + LOOK_LEN;
  localparam int unsigned IDX_W   = $clog2(WIN_LEN);
  localparam int unsigned CNT_W   = $clog2(LOOK_LEN + 1);
  localparam int unsigned S_W     = (SEARCH_LEN > 1) ? $clog2(SEARCH_LEN) : 1;

  typedef enum logic [2:0] {FILL, SEARCH, EMIT, SHIFT, DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] win [WIN_LEN];
  logic [CNT_W-1:0]  look_cnt;
  logic [CNT_W-1:0]  rem;
  logic              term_seen;
  logic [LEN_W-1:0]  lim;
  logic [LEN_W-1:0]  probe_len;
  logic [LEN_W-1:0]  cand_len;
  logic [S_W-1:0]    cand_s;
  logic              search_done;

`ifndef LZ77_PARALLEL_SEARCH_EN
  logic [S_W-1:0]    s_cnt;
  logic [LEN_W-1:0]  best_len;
  logic [S_W-1:0]    best_s;
`endif

  assign encode = 1'b1;

  always_comb begin
    lim = '0;
    if (look_cnt == CNT_W'(LOOK_LEN)) lim = LEN_W'(LOOK_LEN - 1);
    else if (look_cnt != '0)          lim = LEN_W'(look_cnt - 1'b1);
  end

  // Leading run of equal symbols between the candidate at s and the look-ahead; may run into the look-ahead itself.
  function automatic logic [LEN_W-1:0] match_at(input int unsigned s);
    logic [LEN_W-1:0] n;
    logic             run;
    n   = '0;
    run = 1'b1;
    for (int unsigned k = 0; k < LOOK_LEN - 1; k++) begin
      if (run && (LEN_W'(k) < lim) && (win[IDX_W'(s + k)] == win[IDX_W'(SEARCH_LEN + k)]))
        n = n + 1'b1;
      else
        run = 1'b0;
    end
    return n;
  endfunction

`ifdef LZ77_PARALLEL_SEARCH_EN
  always_comb begin
    cand_len    = '0;
    cand_s      = '0;
    probe_len   = '0;
    search_done = 1'b1;
    for (int unsigned s = 0; s < SEARCH_LEN; s++) begin
      probe_len = match_at(s);
      if (probe_len > cand_len) begin
        cand_len = probe_len;
        cand_s   = S_W'(s);
      end
    end
  end
`else
  // Running best merged with the candidate under test this cycle; strict > keeps the earliest s on ties.
  always_comb begin
    probe_len   = match_at(32'(s_cnt));
    cand_len    = best_len;
    cand_s      = best_s;
    search_done = (s_cnt == S_W'(SEARCH_LEN - 1));
    if (probe_len > best_len) begin
      cand_len = probe_len;
      cand_s   = s_cnt;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= FILL;
      look_cnt  <= '0;
      rem       <= '0;
      term_seen <= 1'b0;
      for (int unsigned i = 0; i < WIN_LEN; i++) win[IDX_W'(i)] <= FILL_CHAR;
      valid     <= 1'b0;
      finish    <= 1'b0;
      offset    <= '0;
      match_len <= '0;
      char_nxt  <= '0;
      in_ready  <= 1'b0;
`ifndef LZ77_PARALLEL_SEARCH_EN
      s_cnt     <= '0;
      best_len  <= '0;
      best_s    <= '0;
`endif
    end else begin
      case (state)
        FILL: begin
          if (look_cnt == CNT_W'(LOOK_LEN) || term_seen) begin
            state    <= SEARCH;
            in_ready <= 1'b0;
`ifndef LZ77_PARALLEL_SEARCH_EN
            s_cnt    <= '0;
            best_len <= '0;
            best_s   <= '0;
`endif
          end else if (in_valid && in_ready) begin
            win[IDX_W'(SEARCH_LEN) + IDX_W'(look_cnt)] <= chardata;
            look_cnt <= look_cnt + 1'b1;
            if (chardata == TERM_CHAR) term_seen <= 1'b1;
            // in_ready is registered, so it is computed for the post-write fill level.
            in_ready <= (32'(look_cnt) + 1 < LOOK_LEN) && (chardata != TERM_CHAR);
          end else begin
            in_ready <= 1'b1;
          end
        end

        SEARCH: begin
          if (search_done) begin
            state     <= EMIT;
            valid     <= 1'b1;
            match_len <= cand_len;
            offset    <= (cand_len == '0) ? '0 : OFF_W'(SEARCH_LEN - 1 - 32'(cand_s));
            char_nxt  <= win[IDX_W'(SEARCH_LEN) + IDX_W'(cand_len)];
          end
`ifndef LZ77_PARALLEL_SEARCH_EN
          else begin
            s_cnt    <= s_cnt + 1'b1;
            best_len <= cand_len;
            best_s   <= cand_s;
          end
`endif
        end

        EMIT: begin
          if (out_ready) begin
            valid <= 1'b0;
            if (char_nxt == TERM_CHAR) begin
              finish <= 1'b1;
              state  <= DONE;
            end else begin
              state <= SHIFT;
              rem   <= CNT_W'(match_len) + 1'b1;
            end
          end
        end

        SHIFT: begin
          for (int unsigned i = 0; i < WIN_LEN - 1; i++) win[IDX_W'(i)] <= win[IDX_W'(i + 1)];
          win[IDX_W'(WIN_LEN - 1)] <= FILL_CHAR;
          look_cnt <= look_cnt - 1'b1;
          rem      <= rem - 1'b1;
          if (rem == CNT_W'(1)) begin
            state    <= FILL;
            in_ready <= !term_seen;
          end
        end

        DONE: begin
          valid    <= 1'b0;
          in_ready <= 1'b0;
          finish   <= 1'b1;
        end

        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_lz77_stream_encoder.sv
// Scoreboard bench for lz77_stream_encoder: expected tokens queued with the stimulus, popped on each output handshake.
module tb_lz77_stream_encoder;

  localparam logic [7:0] TERM = 8'h24;
`ifdef LZ77_PARALLEL_SEARCH_EN
  localparam int LAT_EXP = 2;
`else
  localparam int LAT_EXP = 10;
`endif

  typedef struct packed {
    logic [3:0] off;
    logic [2:0] len;
    logic [7:0] ch;
  } tok_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] chardata = '0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       valid;
  logic       out_ready = 1'b0;
  logic       encode;
  logic       finish;
  logic [3:0] offset;
  logic [2:0] match_len;
  logic [7:0] char_nxt;

  int         n_tests = 0;
  int         n_fail = 0;
  int         lat;
  logic [7:0] stim_q[$];
  tok_t       exp_q[$];

  lz77_stream_encoder #(
    .DATA_W(8), .SEARCH_LEN(9), .LOOK_LEN(8), .OFF_W(4), .LEN_W(3),
    .TERM_CHAR(8'h24), .FILL_CHAR(8'h00)
  ) dut (
    .clk(clk), .reset(reset), .chardata(chardata), .in_valid(in_valid), .in_ready(in_ready),
    .valid(valid), .out_ready(out_ready), .encode(encode), .finish(finish),
    .offset(offset), .match_len(match_len), .char_nxt(char_nxt)
  );

  always #5 clk = ~clk;

  task automatic reset_dut();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    stim_q.delete(); exp_q.delete();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic load(input string s);
    for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
  endtask

  task automatic push_tok(input int o, input int l, input logic [7:0] c);
    tok_t t;
    t = {4'(o), 3'(l), c};
    exp_q.push_back(t);
  endtask

  // Reference tokens from a flat history: FILL_CHAR prefix followed by the stream.
  task automatic model_tokens();
    logic [7:0] ext[$];
    int p, avail, lm, best, bo, l;
    for (int i = 0; i < 9; i++) ext.push_back(8'h00);
    foreach (stim_q[i]) ext.push_back(stim_q[i]);
    p = 9;
    while (p < ext.size()) begin
      avail = ext.size() - p;
      if (avail > 8) avail = 8;
      lm = (avail - 1 > 7) ? 7 : avail - 1;
      best = 0; bo = 0;
      for (int d = 9; d >= 1; d--) begin
        l = 0;
        while (l < lm && ext[p - d + l] == ext[p + l]) l++;
        if (l > best) begin best = l; bo = d - 1; end
      end
      push_tok(bo, best, ext[p + best]);
      if (ext[p + best] == TERM) break;
      p += best + 1;
    end
  endtask

  task automatic run_stream(input bit iv_rand, input bit or_rand, input int hold,
                            input int stop_tok, input int budget, output int lat_o);
    int idx, cyc, fill_edge, hold_left, n_hs, stop_wait;
    bit acc_in, acc_out, prev_out, captured, done, term_next;
    tok_t cur, held, e;
    idx = 0; cyc = 0; fill_edge = -1; lat_o = -1; hold_left = hold; n_hs = 0; stop_wait = 6;
    prev_out = 0; captured = 0; done = 0; term_next = 0; held = '0;
    in_valid  = (stim_q.size() > 0) && (!iv_rand || $urandom_range(0, 2) != 0);
    chardata  = in_valid ? stim_q[0] : 8'($urandom);
    out_ready = (hold_left == 0) && (!or_rand || $urandom_range(0, 2) != 0);
    while (!done && cyc < budget) begin
      @(negedge clk);
      cur = {offset, match_len, char_nxt};
      acc_in = in_valid && in_ready;
      acc_out = valid && out_ready;
      if (acc_in) fill_edge = cyc + 1;
      if (valid && lat_o < 0 && fill_edge >= 0) lat_o = cyc - fill_edge;
      if (term_next) begin
        n_tests++;
        if ({finish, valid, in_ready} !== 3'b100) begin
          n_fail++;
          $display("FAIL done_state: finish,valid,in_ready=%b required 100", {finish, valid, in_ready});
        end
        done = 1;
      end else if (prev_out) begin
        n_tests++;
        if (valid !== 1'b0) begin
          n_fail++;
          $display("FAIL valid_drop: valid=%b after handshake, required 0", valid);
        end
      end
      if (hold_left > 0 && (captured || valid)) begin
        if (!captured) begin
          held = cur; captured = 1;
        end else begin
          n_tests++;
          if (valid !== 1'b1 || cur !== held) begin
            n_fail++;
            $display("FAIL hold_stable: valid=%b tok=%h required valid=1 tok=%h", valid, cur, held);
          end
        end
        hold_left--;
      end
      prev_out = acc_out;
      if (acc_out) begin
        n_hs++;
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL token_extra: got (%0d,%0d,%h) with no token expected", offset, match_len, char_nxt);
        end else begin
          e = exp_q.pop_front();
          if (cur !== e || finish !== 1'b0) begin
            n_fail++;
            $display("FAIL token: got (%0d,%0d,%h) finish=%b required (%0d,%0d,%h) finish=0",
                     offset, match_len, char_nxt, finish, e.off, e.len, e.ch);
          end
          term_next = (e.ch == TERM);
        end
      end
      if (stop_tok > 0 && n_hs >= stop_tok) begin
        if (stop_wait == 0) done = 1;
        else stop_wait--;
      end
      if (!done) begin
        @(posedge clk);
        cyc++;
        #1;
        if (acc_in) idx++;
        in_valid  = (idx < stim_q.size()) && (!iv_rand || $urandom_range(0, 2) != 0);
        chardata  = in_valid ? stim_q[idx] : 8'($urandom);
        out_ready = (hold_left == 0) && (stop_tok == 0 || n_hs < stop_tok) &&
                    (!or_rand || $urandom_range(0, 2) != 0);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (!done || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL stream_end: done=%0d pending=%0d required done=1 pending=0", done, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      chardata = 8'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n_tests++;
      if ({valid, finish, in_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_ctrl: valid,finish,in_ready=%b required 000", {valid, finish, in_ready});
      end
      n_tests++;
      if ({offset, match_len, char_nxt} !== 15'h0) begin
        n_fail++;
        $display("FAIL reset_token: (%0d,%0d,%h) required (0,0,00)", offset, match_len, char_nxt);
      end
      n_tests++;
      if (encode !== 1'b1) begin
        n_fail++;
        $display("FAIL encode: %b required 1", encode);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_abab();
    reset_dut();
    load("ABABABAB$");
    push_tok(0, 0, "A"); push_tok(0, 0, "B"); push_tok(1, 6, TERM);
    run_stream(0, 0, 0, 0, 400, lat);
    in_valid = 1'b1;
    chardata = "A";
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_tests++;
      if ({in_ready, valid, finish} !== 3'b001) begin
        n_fail++;
        $display("FAIL done_ignore: in_ready,valid,finish=%b required 001", {in_ready, valid, finish});
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_single_term();
    reset_dut();
    load("$");
    push_tok(0, 0, TERM);
    run_stream(0, 0, 0, 0, 200, lat);
  endtask

  task automatic test_backpressure();
    reset_dut();
    load("ABABABAB$");
    push_tok(0, 0, "A"); push_tok(0, 0, "B"); push_tok(1, 6, TERM);
    run_stream(0, 0, 5, 0, 400, lat);
  endtask

  task automatic test_run_a();
    reset_dut();
    load("AAAAAAAAAAAA$");
    push_tok(0, 0, "A"); push_tok(0, 7, "A"); push_tok(8, 3, TERM);
    run_stream(0, 0, 0, 0, 400, lat);
  endtask

  task automatic test_reset_mid();
    reset_dut();
    load("ABABABAB$");
    push_tok(0, 0, "A");
    run_stream(0, 0, 0, 1, 400, lat);
    reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({valid, finish, in_ready, offset, match_len, char_nxt} !== 18'h0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b finish=%b in_ready=%b tok=(%0d,%0d,%h) required all zero",
               valid, finish, in_ready, offset, match_len, char_nxt);
    end
    stim_q.delete();
    exp_q.delete();
    load("XY$");
    push_tok(0, 0, "X"); push_tok(0, 0, "Y"); push_tok(0, 0, TERM);
    run_stream(0, 0, 0, 0, 400, lat);
    n_tests++;
    if (lat !== LAT_EXP) begin
      n_fail++;
      $display("FAIL fill_latency: %0d cycles required %0d", lat, LAT_EXP);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 2; r++) begin
      reset_dut();
      for (int i = 0; i < 30; i++) stim_q.push_back(8'h41 + 8'($urandom_range(0, 2)));
      stim_q.push_back(TERM);
      model_tokens();
      run_stream(1, 1, 0, 0, 5000, lat);
    end
  endtask

  initial begin
    test_reset();
    test_abab();
    test_single_term();
    test_backpressure();
    test_run_a();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
